// File: rtl/dcache_responder.sv
// Direct-mapped write-back, write-allocate data cache with a single-cycle mem_resp handshake and a 256-bit line port.
// Optional hit/miss counters when DCACHE_PERF_CNT_EN is defined.
module dcache_responder #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [1:0]   dbg_state
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);
    // Handshake: the CPU holds mem_read/mem_write and operands stable until a one-cycle
    // mem_resp; pmem_read/pmem_write stay high until a one-cycle pmem_resp.
    localparam int SETS  = 2 ** S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FILL      = 2'd2;

    logic [1:0]       r_state;
    logic [SETS-1:0]  r_valid;
    logic [SETS-1:0]  r_dirty;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [255:0]     r_data [SETS];
    logic [26:0]      r_miss_line;

    logic [S_INDEX-1:0] w_index;
    logic [S_INDEX-1:0] w_miss_index;
    logic [TAG_W-1:0]   w_tag;
    logic [TAG_W-1:0]   w_miss_tag;
    logic [2:0]         w_word;
    logic               w_req;
    logic               w_hit;
    logic               w_idle_hit;
    logic               w_idle_miss;
    logic [255:0]       w_line;
    logic [31:0]        w_cur_word;
    logic [31:0]        w_merged;
    logic               w_unused;

    assign w_index      = mem_address[4+S_INDEX:5];
    assign w_tag        = mem_address[31:5+S_INDEX];
    assign w_word       = mem_address[4:2];
    assign w_miss_index = r_miss_line[S_INDEX-1:0];
    assign w_miss_tag   = r_miss_line[26:S_INDEX];
    assign w_unused     = ^mem_address[1:0];
    assign w_req        = mem_read | mem_write;
    assign w_line       = r_data[w_index];
    assign w_cur_word   = w_line[{w_word, 5'b0} +: 32];
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_idle_hit   = (r_state == IDLE) && w_req && w_hit;
    assign w_idle_miss  = (r_state == IDLE) && w_req && !w_hit;
    assign dbg_state    = r_state;

    always_comb begin
        w_merged = w_cur_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                w_merged[8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        mem_resp     = w_idle_hit;
        mem_rdata    = w_idle_hit ? w_cur_word : 32'h0;
        pmem_read    = (r_state == FILL);
        pmem_write   = (r_state == WRITEBACK);
        pmem_address = 32'h0;
        pmem_wdata   = '0;
        if (r_state == WRITEBACK) begin
            pmem_address = {r_tag[w_miss_index], w_miss_index, 5'b0};
            pmem_wdata   = r_data[w_miss_index];
        end else if (r_state == FILL) begin
            pmem_address = {w_miss_tag, w_miss_index, 5'b0};
        end
    end

    // The missing line address is captured on entry so WRITEBACK/FILL never look at CPU inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_miss_line <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_idle_hit && mem_write) begin
                        r_dirty[w_index] <= 1'b1;
                    end else if (w_idle_miss) begin
                        r_miss_line <= mem_address[31:5];
                        r_state     <= (r_valid[w_index] && r_dirty[w_index]) ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        r_dirty[w_miss_index] <= 1'b0;
                        r_state               <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        r_valid[w_miss_index] <= 1'b1;
                        r_dirty[w_miss_index] <= 1'b0;
                        r_state               <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_idle_hit && mem_write) begin
                r_data[w_index][{w_word, 5'b0} +: 32] <= w_merged;
            end
            if ((r_state == FILL) && pmem_resp) begin
                r_data[w_miss_index] <= pmem_rdata;
                r_tag[w_miss_index]  <= w_miss_tag;
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic r_after_miss;

    // A request that missed completes with a hit-looking response; it is not counted as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count    <= 32'h0;
            miss_count   <= 32'h0;
            r_after_miss <= 1'b0;
        end else begin
            if (w_idle_miss) begin
                r_after_miss <= 1'b1;
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'h1;
            end
            if (w_idle_hit) begin
                r_after_miss <= 1'b0;
                if (!r_after_miss && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'h1;
            end
        end
    end
`endif

    a_no_read_and_write: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: architectural reference memory plus a backing-store pmem model.
// Read expectations are queued when a request is driven and compared when mem_resp arrives.
module tb_dcache_responder;
  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [1:0]   dbg_state;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  dcache_responder dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .dbg_state(dbg_state)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] bk_mem  [logic [29:0]];
  int wb_count = 0;
  int fill_count = 0;
  logic [31:0] last_wb_addr = 32'h0;
  logic [31:0] last_fill_addr = 32'h0;
  int last_lat;
  int last_cyc;
  logic last_hit;
  int exp_hits = 0;
  int exp_misses = 0;

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {2'b10, w[13:0], ~w[15:0]} ^ 32'h5a5a_0000;
  endfunction

  function automatic logic [31:0] ref_get(input logic [29:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  function automatic logic [31:0] bk_get(input logic [29:0] w);
    if (bk_mem.exists(w)) return bk_mem[w];
    return init_word(w);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One CPU request; also acts as the pmem responder with random 1..3 cycle latency.
  task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
    int cyc;
    int pend;
    bit done;
    logic [31:0] merged;
    logic [29:0] wa;
    wa = addr[31:2];
    if (wr) begin
      merged = ref_get(wa);
      for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[wa] = merged;
    end else begin
      exp_q.push_back(ref_get(wa));
    end
    @(negedge clk);
    mem_read = !wr;
    mem_write = wr;
    mem_address = addr;
    mem_wdata = wdata;
    mem_byte_enable = be;
    cyc = 0;
    pend = 0;
    done = 0;
    last_lat = 0;
    while (!done && cyc < 100) begin
      #1;
      if (mem_resp) begin
        if (!wr) check("rdata", mem_rdata, exp_q.pop_front());
        done = 1;
      end else if (pmem_read || pmem_write) begin
        if (pend == 0) begin
          pend = $urandom_range(1, 3);
          last_lat += pend;
          if (pmem_write) begin
            wb_count++;
            last_wb_addr = pmem_address;
          end else begin
            fill_count++;
            last_fill_addr = pmem_address;
          end
        end
        pend--;
        if (pend == 0) begin
          pmem_resp = 1'b1;
          for (int i = 0; i < 8; i++) begin
            if (pmem_write) bk_mem[{pmem_address[31:5], 3'(i)}] = pmem_wdata[32*i +: 32];
            else pmem_rdata[32*i +: 32] = bk_get({pmem_address[31:5], 3'(i)});
          end
        end
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!done) cyc++;
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    check("resp_seen", {31'b0, done}, 32'h1);
    if (!done && !wr) void'(exp_q.pop_front());
    last_cyc = cyc;
    last_hit = (cyc == 0);
    if (cyc == 0) exp_hits++;
    else exp_misses++;
  endtask

  task automatic idle_check(input string tag);
    #1;
    check({tag, "_resp"}, {31'b0, mem_resp}, 32'h0);
    check({tag, "_rdata"}, mem_rdata, 32'h0);
    check({tag, "_pmem_rd"}, {31'b0, pmem_read}, 32'h0);
    check({tag, "_pmem_wr"}, {31'b0, pmem_write}, 32'h0);
    check({tag, "_pmem_addr"}, pmem_address, 32'h0);
    check({tag, "_state"}, {30'b0, dbg_state}, 32'h0);
  endtask

  initial begin
    int f0;
    int w0;
    logic [31:0] addr;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = 32'h0;
    mem_wdata = 32'h0;
    mem_byte_enable = 4'h0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    ref_mem[30'h10] = 32'hDEAD_BEEF;
    bk_mem[30'h10] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_check("reset");
`ifdef DCACHE_PERF_CNT_EN
    check("rst_hit_count", hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
`endif

    // Clean miss fill, then the same request hits
    cpu_access(1'b0, 32'h40, 32'h0, 4'h0);
    check("t1_fill_addr", last_fill_addr, 32'h40);
    check("t1_fill_count", 32'(fill_count), 32'd1);
    check("t1_wb_count", 32'(wb_count), 32'd0);
    check("t1_miss_latency", 32'(last_cyc + 1), 32'(last_lat + 2));

    // Partial store hit, then read back the merged word
    cpu_access(1'b1, 32'h44, 32'hAABB_CCDD, 4'b0101);
    check("t2_write_hit_lat0", {31'b0, last_hit}, 32'h1);
    cpu_access(1'b0, 32'h44, 32'h0, 4'h0);
    check("t2_read_hit_lat0", {31'b0, last_hit}, 32'h1);
    @(negedge clk);
    idle_check("idle");

    // Dirty eviction of set 2 by a new tag
    w0 = wb_count;
    cpu_access(1'b0, 32'h440, 32'h0, 4'h0);
    check("t3_wb_count", 32'(wb_count - w0), 32'd1);
    check("t3_wb_addr", last_wb_addr, 32'h40);
    check("t3_fill_addr", last_fill_addr, 32'h440);
    check("t3_wb_data_w1", bk_get(30'h11), ref_get(30'h11));
    check("t3_wb_data_w0", bk_get(30'h10), 32'hDEAD_BEEF);
    check("t3_miss_latency", 32'(last_cyc + 1), 32'(last_lat + 2));
    cpu_access(1'b0, 32'h40, 32'h0, 4'h0);
    check("t3_refill_addr", last_fill_addr, 32'h40);

    // Reset while a fill is outstanding
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 32'h80;
    @(negedge clk);
    #1;
    check("t4_fill_before_rst", {31'b0, pmem_read}, 32'h1);
    check("t4_fill_addr_before_rst", pmem_address, 32'h80);
    rst = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    check("t4_pmem_rd_after_rst", {31'b0, pmem_read}, 32'h0);
    check("t4_state_after_rst", {30'b0, dbg_state}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
`ifdef DCACHE_PERF_CNT_EN
    #1;
    check("t4_hit_count_rst", hit_count, 32'h0);
    check("t4_miss_count_rst", miss_count, 32'h0);
`endif
    f0 = fill_count;
    cpu_access(1'b0, 32'h40, 32'h0, 4'h0);
    check("t4_miss_after_rst", {31'b0, last_hit}, 32'h0);
    check("t4_refill_count", 32'(fill_count - f0), 32'd1);
    cpu_access(1'b0, 32'h80, 32'h0, 4'h0);
    check("t4_fill_addr_again", last_fill_addr, 32'h80);

    // All word offsets of set 0, lane-3 store, zero-enable store
    for (int i = 0; i < 8; i++) cpu_access(1'b0, 32'(i * 4), 32'h0, 4'h0);
    cpu_access(1'b1, 32'h1C, 32'h5A12_3456, 4'b1000);
    cpu_access(1'b1, 32'h18, 32'hFFFF_FFFF, 4'b0000);
    check("t5_be0_hit_lat0", {31'b0, last_hit}, 32'h1);
    for (int i = 0; i < 8; i++) cpu_access(1'b0, 32'(i * 4), 32'h0, 4'h0);

    // Random mix over 4 tags x 8 sets
    for (int n = 0; n < 80; n++) begin
      addr = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5)
           | (32'($urandom_range(0, 7)) << 2);
      cpu_access(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
    end

`ifdef DCACHE_PERF_CNT_EN
    check("perf_hit_count", hit_count, 32'(exp_hits));
    check("perf_miss_count", miss_count, 32'(exp_misses));
`endif
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
